// File: rtl/ipml_fifo_wconv_pkg.sv
// Shared helpers for the width-converting FIFO: sizing functions and parameter legality.
package ipml_fifo_wconv_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < v; i = i * 2) r++;
    return r;
  endfunction

  // Lane count spans 0..R, so it needs one bit more than log2(R).
  function automatic int unsigned lane_cnt_w(input int unsigned r);
    return clog2(r) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_ok(input int unsigned w, input int unsigned r,
                                input int unsigned dw, input int unsigned af,
                                input int unsigned ae);
    return (w >= 1) && (w <= 64) && is_pow2(r) && (r <= 32) && (dw >= 2) && (dw <= 10) &&
           (af < (1 << dw)) && (ae < (1 << dw));
  endfunction

endpackage

// File: rtl/ipml_fifo_wconv_if.sv
// Write/read bus of the width-converting FIFO; slave modport faces the FIFO.
interface ipml_fifo_wconv_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned R  = 16,
  parameter int unsigned AW = 5,
  parameter int unsigned LW = ipml_fifo_wconv_pkg::lane_cnt_w(R)
);
  logic [W-1:0]   wr_data;
  logic           wr_en;
  logic           wr_flush;
  logic           wr_full;
  logic           almost_full;
  logic           wr_err;
  logic           rd_en;
  logic [W*R-1:0] rd_data;
  logic [LW-1:0]  rd_lanes;
  logic           rd_empty;
  logic           almost_empty;
  logic           rd_err;
  logic [AW:0]    water_level;

  modport master (
    output wr_data, wr_en, wr_flush, rd_en,
    input  wr_full, almost_full, wr_err, rd_data, rd_lanes, rd_empty, almost_empty, rd_err,
           water_level
  );

  modport slave (
    input  wr_data, wr_en, wr_flush, rd_en,
    output wr_full, almost_full, wr_err, rd_data, rd_lanes, rd_empty, almost_empty, rd_err,
           water_level
  );
endinterface

// File: rtl/ipml_fifo_wconv_packer.sv
// Packs narrow lanes into a wide word; pushes on the last lane or on a flush with lanes pending.
module ipml_fifo_wconv_packer
  import ipml_fifo_wconv_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned R  = 16,
  parameter int unsigned LW = lane_cnt_w(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   wr_data_i,
  input  logic           wr_en_i,
  input  logic           wr_flush_i,
  input  logic           full_i,
  output logic           push_o,
  output logic [W*R-1:0] word_o,
  output logic [LW-1:0]  lanes_o,
  output logic           wr_err_o
);
  localparam int unsigned KW = (R > 1) ? clog2(R) : 1;

  logic [KW-1:0]  k_q, k_d;
  logic [W*R-1:0] buf_q, buf_d;
  logic           err_q, err_d;
  logic [LW-1:0]  pend;

  // buf_q keeps unwritten lanes at zero so a flushed word needs no extra masking.
  always_comb begin
    k_d     = k_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    push_o  = 1'b0;
    word_o  = buf_q;
    lanes_o = '0;
    pend    = LW'(k_q) + LW'(wr_en_i);
    if (full_i) begin
      err_d = wr_en_i | wr_flush_i;
    end else begin
      if (wr_en_i) word_o[k_q*W +: W] = wr_data_i;
      push_o = (wr_en_i && (k_q == KW'(R - 1))) || (wr_flush_i && (pend != '0));
      if (push_o) begin
        lanes_o = pend;
        k_d     = '0;
        buf_d   = '0;
      end else if (wr_en_i) begin
        buf_d = word_o;
        k_d   = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      buf_q <= '0;
      err_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      buf_q <= buf_d;
      err_q <= err_d;
    end
  end

  assign wr_err_o = err_q;
endmodule

// File: rtl/ipml_fifo_wconv_v1_0.sv
// N:1 upsizing FIFO top: storage, pointers, count, flags and read stage.
// Define IPML_FIFO_WCONV_FWFT_EN for first-word-fall-through reads.
module ipml_fifo_wconv_v1_0
  import ipml_fifo_wconv_pkg::*;
#(
  parameter int unsigned c_WR_DATA_WIDTH   = 16,
  parameter int unsigned c_PACK_RATIO      = 16,
  parameter int unsigned c_RD_DEPTH_WIDTH  = 5,
  parameter int unsigned c_ALMOST_FULL_NUM = 28,
  parameter int unsigned c_ALMOST_EMPTY_NUM = 2
) (
  input logic             clk,
  input logic             rst,
  ipml_fifo_wconv_if.slave bus
);
  localparam int unsigned W   = c_WR_DATA_WIDTH;
  localparam int unsigned R   = c_PACK_RATIO;
  localparam int unsigned AW  = c_RD_DEPTH_WIDTH;
  localparam int unsigned Dep = 2 ** AW;
  localparam int unsigned LW  = lane_cnt_w(R);
  localparam int unsigned DW  = W * R;

  if (!cfg_ok(W, R, AW, c_ALMOST_FULL_NUM, c_ALMOST_EMPTY_NUM)) begin : g_cfg_err
    $error("ipml_fifo_wconv_v1_0: illegal parameter set");
  end

  logic          pk_push;
  logic [DW-1:0] pk_word;
  logic [LW-1:0] pk_lanes;
  logic          full, empty, pop, load;

  logic [DW-1:0] mem_data_q  [Dep];
  logic [LW-1:0] mem_lanes_q [Dep];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q;
  logic [LW-1:0] rd_lanes_q;
  logic          rd_err_q;

  ipml_fifo_wconv_packer #(
    .W  (W),
    .R  (R),
    .LW (LW)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (bus.wr_data),
    .wr_en_i    (bus.wr_en),
    .wr_flush_i (bus.wr_flush),
    .full_i     (full),
    .push_o     (pk_push),
    .word_o     (pk_word),
    .lanes_o    (pk_lanes),
    .wr_err_o   (bus.wr_err)
  );

  assign full  = (cnt_q == (AW+1)'(Dep));
  assign cnt_d = cnt_q + (AW+1)'(pk_push) - (AW+1)'(pop);

`ifdef IPML_FIFO_WCONV_FWFT_EN
  // cnt_q includes the output stage, so storage holds cnt_q - ov_q words.
  logic ov_q;
  assign empty = !ov_q;
  assign pop   = bus.rd_en && ov_q;
  assign load  = (cnt_q != (AW+1)'(ov_q)) && (!ov_q || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
    end else if (load) begin
      ov_q <= 1'b1;
    end else if (pop) begin
      ov_q <= 1'b0;
    end
  end
`else
  assign empty = (cnt_q == '0);
  assign pop   = bus.rd_en && !empty;
  assign load  = pop;
`endif

  always_ff @(posedge clk) begin
    if (pk_push) begin
      mem_data_q[wp_q]  <= pk_word;
      mem_lanes_q[wp_q] <= pk_lanes;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_lanes_q <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_err_q <= bus.rd_en && empty;
      if (pk_push) wp_q <= wp_q + 1'b1;
      if (load) begin
        rp_q       <= rp_q + 1'b1;
        rd_data_q  <= mem_data_q[rp_q];
        rd_lanes_q <= mem_lanes_q[rp_q];
      end
    end
  end

  assign bus.wr_full      = full;
  assign bus.almost_full  = (cnt_q >= (AW+1)'(c_ALMOST_FULL_NUM));
  assign bus.almost_empty = (cnt_q <= (AW+1)'(c_ALMOST_EMPTY_NUM));
  assign bus.rd_empty     = empty;
  assign bus.rd_err       = rd_err_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_lanes     = rd_lanes_q;
  assign bus.water_level  = cnt_q;
endmodule

// File: doc/ipml_fifo_wconv_v1_0.md
# ipml_fifo_wconv_v1_0

Single-clock, parametrised width-converting FIFO that packs narrow write beats into wide read words (N:1 upsizing), with explicit flush of partial words and a per-word valid-lane count. It generalises the fixed 16-bit-in/256-bit-out FIFO so that any power-of-two pack ratio and depth can be used. It sits between narrow video/stream sources and wide DDR/AXI write paths inside one clock domain.

## Interface
- c_WR_DATA_WIDTH, 16, narrow write lane width W (1..64)
- c_PACK_RATIO, 16, lanes per read word R; power of two, 1..32; read width = W*R
- c_RD_DEPTH_WIDTH, 5, log2 of storage depth in wide words (2..10); depth DEP = 2^c_RD_DEPTH_WIDTH
- c_ALMOST_FULL_NUM, 28, almost_full threshold in wide words
- c_ALMOST_EMPTY_NUM, 2, almost_empty threshold in wide words
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- wr_data  in  W  narrow write lane
- wr_en  in  1  write one lane
- wr_flush  in  1  push partial packer word (after same-cycle wr_en lane)
- wr_full  out  1  storage holds DEP words; writes and flushes rejected
- almost_full  out  1  word count >= c_ALMOST_FULL_NUM
- wr_err  out  1  one-cycle pulse: wr_en or wr_flush rejected
- rd_en  in  1  read/pop one wide word
- rd_data  out  W*R  wide word; lane i at bits [i*W +: W]
- rd_lanes  out  log2(R)+1  valid lanes in rd_data (1..R)
- rd_empty  out  1  no word available
- almost_empty  out  1  word count <= c_ALMOST_EMPTY_NUM
- rd_err  out  1  one-cycle pulse: rd_en rejected while empty
- water_level  out  c_RD_DEPTH_WIDTH+1  stored wide words (0..DEP)

## Operation
- Packer: lane counter k (0..R-1) plus R-1 lane registers; lane 0 is first written (LSBs).
- wr_en accepted when !wr_full: lane stored at index k; if k==R-1 the full word (lanes=R) is pushed and k->0, else k++.
- wr_flush accepted when !wr_full: if lanes pending (k>0, or wr_en this cycle) push word with lanes=pending count, unused lanes zero, k->0. Flush with nothing pending: no push, no error.
- wr_en and wr_flush same cycle: lane included, single push.
- When wr_full: wr_en/wr_flush ignored, packer unchanged, wr_err pulses.
- Storage: DEP x (W*R + lane-count) array, write/read pointers c_RD_DEPTH_WIDTH bits wrapping naturally; count c_RD_DEPTH_WIDTH+1 bits.
- rd_en accepted when !rd_empty; rejected otherwise with rd_err pulse.
- Push and pop same cycle: count unchanged. Full/empty decided from registered count: push rejected when full even if pop same cycle; pop rejected when empty even if push same cycle.
- Flags combinational from registered count; water_level = count.

## Timing
- Standard mode: rd_data/rd_lanes registered, valid 1 cycle after accepted rd_en; hold otherwise.
- Word pushed on cycle N: rd_empty low in cycle N+1.
- Reset values: rd_data 0, rd_lanes 0, rd_empty 1, wr_full 0, almost_full 0, almost_empty 1, wr_err 0, rd_err 0, water_level 0, k 0, pointers 0.
- Reset mid-operation: stored words and partial packer discarded; no push on reset release.

## Configuration
- IPML_FIFO_WCONV_FWFT_EN defined: first-word-fall-through; head word presented on rd_data/rd_lanes when rd_empty low, rd_en pops and next word appears next cycle; output stage counted in water_level; first word visible 2 cycles after push.
- Undefined: standard mode, 1-cycle read latency as above.

## Structure
- Package ipml_fifo_wconv_pkg: clog2 helper, lane-count width function, parameter legality checks (R power of two, thresholds < DEP).
- Sub-module ipml_fifo_wconv_packer: lane counter, lane registers, push/flush generation; top holds storage, pointers, count, flags, output stage.

## Test plan
- W=16,R=16,DEP=32: write 16 lanes 0x0001..0x0010, read -> rd_data lane0=0x0001, lane15=0x0010, rd_lanes=16, rd_empty returns 1.
- Write 3 lanes 0xA1,0xA2,0xA3 then wr_flush -> one word, rd_lanes=3, lanes 3..15 zero; wr_flush with k=0 -> no push, wr_err 0.
- Fill 32 words -> wr_full=1, almost_full=1 from water_level 28; extra wr_en -> wr_err pulse, water_level stays 32; wr_en+rd_en at full -> write rejected, level 31.
- rd_en on empty -> rd_err pulse, rd_data unchanged; push+rd_en same cycle while empty -> pop rejected, level 1.
- 200 words streamed with random rd_en/wr_en across pointer wrap -> data order and lane counts match model; FWFT build: first word on rd_data 2 cycles after push.
- Assert rst with 10 words + 5 pending lanes -> all outputs at reset values next cycle; subsequent 16 writes form a clean word.
